pulse_period_detector: RTL and testbench

Receive-side companion to the team's clock-divider FSMs. Watches a periodic strobe, such as a divide-by-N output, and measures the number of clk cycles between successive rising edges. Declares lock after LOCK_COUNT consecutive identical periods, and flags mismatches and timeouts. Sits on the checker side of divider/strobe generators, in the same clock domain.

---
 rtl/pulse_period_pkg.sv | 12 +
 rtl/rise_edge_detect.sv | 26 ++
 rtl/pulse_period_detector.sv | 161 ++++++++++++++++
 tb/tb_pulse_period_detector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_period_pkg.sv
// Shared types and limits for the pulse period detector.
//   pd_state_t     : detector FSM state encoding
//   LockCountMax   : largest supported LOCK_COUNT
//   MatchCntW      : width of the matching-period counter
package pulse_period_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, VERIFY, LOCKED} pd_state_t;

  localparam int unsigned LockCountMax = 15;
  localparam int unsigned MatchCntW    = $clog2(LockCountMax + 1);

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for a signal already synchronous to clk.
//   clk   : clock, rising-edge
//   reset : asynchronous, active-high reset (delay register cleared to 0)
//   din   : input level
//   rise  : combinational, high in the cycle din is 1 and was 0 the cycle before
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  // Clearing din_q on reset makes a high input in the first cycle count as an edge.
  assign rise = din & ~din_q;

endmodule

// File: rtl/pulse_period_detector.sv
// Measures the clk-cycle spacing of rising edges on a periodic strobe and
// declares lock once LOCK_COUNT consecutive periods agree.
//   clk          : clock, rising-edge
//   reset        : asynchronous, active-high reset
//   pulse_in     : strobe under test, synchronous to clk
//   period       : last measured period (holds between updates)
//   period_valid : one-cycle pulse when period updates
//   locked       : high while the period is stable
//   mismatch     : one-cycle pulse when a period differs from the reference
//   timeout      : one-cycle pulse when no edge arrives within 2**CNT_W-1 cycles
module pulse_period_detector
  import pulse_period_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]     CntMax     = '1;
  localparam logic [MatchCntW-1:0] LockTarget = MatchCntW'(LOCK_COUNT - 1);

  logic                 rise;
  pd_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     ref_period_q, ref_period_d;
  logic [MatchCntW-1:0] match_cnt_q, match_cnt_d;
  logic [MatchCntW-1:0] match_inc;
  logic [CNT_W-1:0]     period_q, period_d;
  logic                 period_valid_q, period_valid_d;
  logic                 locked_q, locked_d;
  logic                 mismatch_q, mismatch_d;
  logic                 timeout_q, timeout_d;

  rise_edge_detect u_rise_edge_detect (
    .clk   (clk),
    .reset (reset),
    .din   (pulse_in),
    .rise  (rise)
  );

  assign match_inc = match_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    ref_period_d   = ref_period_q;
    match_cnt_d    = match_cnt_q;
    period_d       = period_q;
    locked_d       = locked_q;
    period_valid_d = 1'b0;
    mismatch_d     = 1'b0;
    timeout_d      = 1'b0;

    // cnt holds the number of cycles since the last edge, measured in the edge cycle.
    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          ref_period_d   = cnt_q;
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          match_cnt_d    = '0;
          if (LOCK_COUNT == 1) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (rise) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (cnt_q == ref_period_q) begin
            match_cnt_d = match_inc;
            // >= so that LOCK_COUNT==1 re-locks on the first match after a mismatch.
            if (match_inc >= LockTarget) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            mismatch_d   = 1'b1;
            ref_period_d = cnt_q;
            match_cnt_d  = '0;
          end
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (cnt_q != ref_period_q) begin
            mismatch_d   = 1'b1;
            locked_d     = 1'b0;
            ref_period_d = cnt_q;
            match_cnt_d  = '0;
            state_d      = VERIFY;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge in the saturation cycle is a valid MAX period, so only time out without one.
    if (state_q != IDLE && cnt_q == CntMax && !rise) begin
      timeout_d   = 1'b1;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ref_period_q   <= '0;
      match_cnt_q    <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      mismatch_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ref_period_q   <= ref_period_d;
      match_cnt_q    <= match_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      mismatch_q     <= mismatch_d;
      timeout_q      <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign mismatch     = mismatch_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_detector.sv
module tb_pulse_period_detector;

  localparam int unsigned CntW      = 4;
  localparam int unsigned LockCount = 3;
  localparam int          MaxCnt    = (1 << CntW) - 1;

  logic            clk;
  logic            reset;
  logic            pulse_in;
  logic [CntW-1:0] period;
  logic            period_valid;
  logic            locked;
  logic            mismatch;
  logic            timeout;

  int checks;
  int passed;

  // Reference model: edge times, the run of identical periods and an armed flag.
  int  now;
  int  last_edge;
  bit  prev_in;
  bit  active;
  bit  have_ref;
  int  ref_p;
  int  streak;
  int  exp_period;
  bit  exp_valid;
  bit  exp_locked;
  bit  exp_mis;
  bit  exp_to;

  pulse_period_detector #(
    .CNT_W      (CntW),
    .LOCK_COUNT (LockCount)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .mismatch     (mismatch),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, expv, $time);
  endtask

  task automatic compare_all();
    chk("period", int'(period), exp_period);
    chk("period_valid", int'(period_valid), int'(exp_valid));
    chk("locked", int'(locked), int'(exp_locked));
    chk("mismatch", int'(mismatch), int'(exp_mis));
    chk("timeout", int'(timeout), int'(exp_to));
  endtask

  task automatic model_reset();
    now        = 0;
    last_edge  = 0;
    prev_in    = 1'b0;
    active     = 1'b0;
    have_ref   = 1'b0;
    ref_p      = 0;
    streak     = 0;
    exp_period = 0;
    exp_valid  = 1'b0;
    exp_locked = 1'b0;
    exp_mis    = 1'b0;
    exp_to     = 1'b0;
  endtask

  // Predicts the outputs visible after the coming clock edge for input level p.
  task automatic model_eval(input bit p);
    bit is_edge;
    int m;
    is_edge   = p && !prev_in;
    prev_in   = p;
    exp_valid = 1'b0;
    exp_mis   = 1'b0;
    exp_to    = 1'b0;
    if (is_edge) begin
      if (!active) begin
        active   = 1'b1;
        have_ref = 1'b0;
        streak   = 0;
      end else begin
        m          = now - last_edge;
        exp_period = m;
        exp_valid  = 1'b1;
        if (have_ref && m == ref_p) begin
          streak++;
        end else begin
          exp_mis  = have_ref;
          ref_p    = m;
          have_ref = 1'b1;
          streak   = 1;
        end
        exp_locked = (streak >= LockCount);
      end
      last_edge = now;
    end else if (active && (now - last_edge) == MaxCnt) begin
      exp_to     = 1'b1;
      exp_locked = 1'b0;
      active     = 1'b0;
    end
    now++;
  endtask

  task automatic step(input bit p);
    pulse_in = p;
    model_eval(p);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // One high cycle followed by gap-1 low cycles.
  task automatic strobe(input int gap);
    step(1'b1);
    for (int i = 1; i < gap; i++) step(1'b0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pulse_in = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    int gap;
    int width;
    int reps;
    checks   = 0;
    passed   = 0;
    reset    = 1'b1;
    pulse_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Period-3 strobe acquires lock on the third period.
    for (int i = 0; i < 4; i++) strobe(3);
    chk("p3_locked", int'(locked), 1);
    chk("p3_period", int'(period), 3);

    // Period change to 5 while locked, then re-lock after two more.
    for (int i = 0; i < 4; i++) strobe(5);
    chk("p5_relock", int'(locked), 1);
    chk("p5_period", int'(period), 5);

    // Lock on 3 then go silent: timeout, period held.
    for (int i = 0; i < 5; i++) strobe(3);
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("to_locked", int'(locked), 0);
    chk("to_period", int'(period), 3);

    // Boundary: 15-cycle spacing is a valid period, 16 times out.
    for (int i = 0; i < 3; i++) strobe(MaxCnt);
    chk("max_period", int'(period), MaxCnt);
    for (int i = 0; i < 3; i++) strobe(MaxCnt + 1);

    // Level-high input: one edge, then timeout, never a period.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("level_period", int'(period), 0);
    step(1'b0);

    // Reset while locked, then re-acquire.
    for (int i = 0; i < 4; i++) strobe(3);
    chk("pre_rst_locked", int'(locked), 1);
    do_reset();
    for (int i = 0; i < 5; i++) strobe(3);
    chk("post_rst_locked", int'(locked), 1);

    // Randomised strobes of varying spacing, width and repetition.
    for (int n = 0; n < 250; n++) begin
      gap   = int'($urandom_range(2, MaxCnt + 3));
      width = int'($urandom_range(1, gap - 1));
      reps  = int'($urandom_range(1, 5));
      for (int r = 0; r < reps; r++) begin
        for (int i = 0; i < gap; i++) step(i < width);
      end
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
